// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the N-channel stream multiplexer.
package stream_mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Index width for a channel count; never narrower than one bit.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 32'sd1;
    r = 32'sd0;
    while (v > 32'sd0) begin
      r = r + 32'sd1;
      v = v >>> 1;
    end
    return (r < 32'sd1) ? 32'sd1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or after ptr.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N = 4,
  localparam int SELW = clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] grant,
  output logic            grant_valid
);

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    logic [SELW-1:0] idx_v;
    logic            hit_v;
    grant       = '0;
    grant_valid = 1'b0;
    idx_v       = '0;
    hit_v       = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      idx_v       = SELW'((int'(ptr) + i) % N);
      hit_v       = req[idx_v];
      grant       = hit_v ? idx_v : grant;
      grant_valid = grant_valid | hit_v;
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// N-channel stream mux with explicit-select and round-robin modes,
// a single registered output stage and a sticky illegal-select flag.
module stream_mux_n
  import stream_mux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SELW = clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  input  logic [N-1:0]      in_valid,
  input  logic [N*W-1:0]    in_data,
  output logic [N-1:0]      in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_ch,
  output logic              sel_err,
  input  logic              err_clr
);

  localparam logic [SELW:0]   N_EXT   = (SELW + 1)'(N);
  localparam logic [SELW-1:0] LAST_CH = SELW'(N - 1);

  logic            out_valid_r;
  logic [W-1:0]    out_data_r;
  logic [SELW-1:0] out_ch_r;
  logic [SELW-1:0] ptr_r;
  logic            sel_err_r;

  logic [SELW-1:0] rr_grant_s;
  logic            rr_valid_s;
  logic            sel_legal_s;
  logic [SELW-1:0] grant_s;
  logic            grant_valid_s;
  logic            free_s;
  logic            xfer_s;
  logic            sel_err_set_s;
  logic [W-1:0]    grant_data_s;
  logic [SELW-1:0] next_ptr_s;

  rr_arbiter #(.N(N)) u_rr (
    .req         (in_valid),
    .ptr         (ptr_r),
    .grant       (rr_grant_s),
    .grant_valid (rr_valid_s)
  );

  // Grant decision; an out-of-range or unknown sel falls to the no-grant branch.
  always_comb begin
    sel_legal_s   = 1'b0;
    grant_s       = '0;
    grant_valid_s = 1'b0;
    if ({1'b0, sel} < N_EXT) begin
      sel_legal_s = 1'b1;
    end else begin
      sel_legal_s = 1'b0;
    end
    if (mode == MODE_RR) begin
      grant_s       = rr_grant_s;
      grant_valid_s = rr_valid_s;
    end else if (sel_legal_s) begin
      grant_s       = sel;
      grant_valid_s = in_valid[sel];
    end else begin
      grant_s       = '0;
      grant_valid_s = 1'b0;
    end
  end

  assign free_s        = !out_valid_r || out_ready;
  assign xfer_s        = free_s && grant_valid_s;
  assign sel_err_set_s = (mode == MODE_SEL) && (|in_valid) && !sel_legal_s;
  assign grant_data_s  = W'(in_data >> (int'(grant_s) * W));
  assign next_ptr_s    = (grant_s == LAST_CH) ? '0 : grant_s + SELW'(1);
  assign in_ready      = (!rst && xfer_s) ? (N'(1) << grant_s) : '0;

  // Output stage, round-robin pointer and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_ch_r    <= '0;
      ptr_r       <= '0;
      sel_err_r   <= 1'b0;
    end else begin
      if (xfer_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= grant_data_s;
        out_ch_r    <= grant_s;
        ptr_r       <= next_ptr_s;
      end else if (free_s) begin
        out_valid_r <= 1'b0;
      end
      if (sel_err_set_s) begin
        sel_err_r <= 1'b1;
      end else if (err_clr) begin
        sel_err_r <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_ch    = out_ch_r;
  assign sel_err   = sel_err_r;

endmodule
